dmem_ctrl: RTL

Data-memory access controller on the CPU side of the word-wide data RAM. Accepts byte/halfword/word load and store requests from the pipeline over a valid/ready handshake, drives the RAM's single word port, and returns load data or store completion over a second valid/ready handshake. Sub-word stores are performed as a read-modify-write because the RAM writes whole words only; the RAM read port is combinational and its write port is synchronous.

---
 rtl/dmem_ctrl_pkg.sv | 11 +
 rtl/dmem_ctrl_if.sv | 26 ++
 rtl/dmem_lane_mux.sv | 26 ++
 rtl/dmem_ctrl.sv | 76 +++++++
 4 files changed

// File: rtl/dmem_ctrl_pkg.sv
// dmem_ctrl_pkg: shared size encodings, FSM states and helpers for the data-memory controller
package dmem_ctrl_pkg;
   localparam int WORD_ADDR_W_DEF = 11;
   localparam logic [1:0] SZ_BYTE = 2'd0;
   localparam logic [1:0] SZ_HALF = 2'd1;
   localparam logic [1:0] SZ_WORD = 2'd2;
   typedef enum logic [1:0] {IDLE, RMW_WR, RESP} state_t;
   function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lo);
      return (size == SZ_HALF && lo[0]) || (size[1] && lo != 2'b00);
   endfunction
endpackage

// File: rtl/dmem_ctrl_if.sv
// dmem_ctrl_if: request/response handshakes and RAM word port of the data-memory controller
interface dmem_ctrl_if import dmem_ctrl_pkg::*; #(parameter int WORD_ADDR_W = WORD_ADDR_W_DEF);
   logic                   req_valid;
   logic                   req_ready;
   logic                   req_we;
   logic [1:0]             req_size;
   logic                   req_unsigned;
   logic [31:0]            req_addr;
   logic [31:0]            req_wdata;
   logic                   rsp_valid;
   logic                   rsp_ready;
   logic [31:0]            rsp_rdata;
   logic                   rsp_err;
   logic [WORD_ADDR_W-1:0] ram_addr;
   logic                   ram_wr_en;
   logic [31:0]            ram_wr_data;
   logic [31:0]            ram_rd_data;
   modport slave (
      input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, rsp_ready, ram_rd_data,
      output req_ready, rsp_valid, rsp_rdata, rsp_err, ram_addr, ram_wr_en, ram_wr_data
   );
   modport master (
      output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, rsp_ready, ram_rd_data,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err, ram_addr, ram_wr_en, ram_wr_data
   );
endinterface

// File: rtl/dmem_lane_mux.sv
// dmem_lane_mux: little-endian load lane extract/extend and store lane merge into a RAM word
module dmem_lane_mux import dmem_ctrl_pkg::*; (
   input  logic [1:0]  size_i,
   input  logic [1:0]  addr_i,
   input  logic        uns_i,
   input  logic [31:0] rd_data_i,
   input  logic [31:0] wdata_i,
   output logic [31:0] ld_data_o,
   output logic [31:0] st_data_o
);
   logic [7:0]  b;
   logic [15:0] h;
   logic [31:0] mask, rep;
   logic        is_b, is_h;
   // extract the addressed lane, extend it, and build the merged store word
   always_comb begin
      is_b      = size_i == SZ_BYTE;
      is_h      = size_i == SZ_HALF;
      b         = rd_data_i[{addr_i, 3'b000} +: 8];
      h         = rd_data_i[{addr_i[1], 4'b0000} +: 16];
      ld_data_o = is_b ? {{24{~uns_i & b[7]}}, b} : is_h ? {{16{~uns_i & h[15]}}, h} : rd_data_i;
      mask      = is_b ? 32'h0000_00ff << {addr_i, 3'b000} : is_h ? 32'h0000_ffff << {addr_i[1], 4'b0000} : 32'hffff_ffff;
      rep       = is_b ? {4{wdata_i[7:0]}} : is_h ? {2{wdata_i[15:0]}} : wdata_i;
      st_data_o = (rd_data_i & ~mask) | (rep & mask);
   end
endmodule

// File: rtl/dmem_ctrl.sv
// dmem_ctrl: CPU-side data-memory controller with read-modify-write sub-word stores (optional DMEM_ALIGN_CHECK_EN)
module dmem_ctrl import dmem_ctrl_pkg::*; #(parameter int WORD_ADDR_W = WORD_ADDR_W_DEF) (
   input logic        clk,
   input logic        resetn,
   dmem_ctrl_if.slave bus
);
   state_t                 state_q, state_d;
   logic [WORD_ADDR_W-1:0] addr_q, addr_d;
   logic [31:0]            wdata_q, wdata_d, rdata_q, rdata_d, ld_data, st_data;
   logic                   err_q, err_d, accept, mis, wr_en;
   logic                   unused_ok;
   assign unused_ok = ^bus.req_addr[31:WORD_ADDR_W+2];
`ifdef DMEM_ALIGN_CHECK_EN
   assign mis = misaligned(bus.req_size, bus.req_addr[1:0]);
`else
   assign mis = 1'b0;
`endif
   dmem_lane_mux u_lane (
      .size_i    (bus.req_size),
      .addr_i    (bus.req_addr[1:0]),
      .uns_i     (bus.req_unsigned),
      .rd_data_i (bus.ram_rd_data),
      .wdata_i   (bus.req_wdata),
      .ld_data_o (ld_data),
      .st_data_o (st_data)
   );
   assign bus.req_ready   = resetn & (state_q == IDLE);
   assign accept          = bus.req_valid & bus.req_ready;
   assign bus.rsp_valid   = state_q == RESP;
   assign bus.rsp_rdata   = rdata_q;
   assign bus.rsp_err     = err_q;
   assign bus.ram_addr    = state_q == IDLE ? bus.req_addr[WORD_ADDR_W+1:2] : addr_q;
   assign bus.ram_wr_en   = wr_en;
   assign bus.ram_wr_data = state_q == RMW_WR ? wdata_q : st_data;
   // state and response registers; reset abandons any pending write or response
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q <= IDLE;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
      end
   end
   // next state: word stores write on accept, sub-word stores write the merged word one cycle later
   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      err_d   = err_q;
      wr_en   = 1'b0;
      case (state_q)
         IDLE: if (accept) begin
            addr_d  = bus.req_addr[WORD_ADDR_W+1:2];
            err_d   = mis;
            rdata_d = (bus.req_we | mis) ? 32'd0 : ld_data;
            wdata_d = st_data;
            wr_en   = bus.req_we & ~mis & bus.req_size[1];
            state_d = (bus.req_we & ~mis & ~bus.req_size[1]) ? RMW_WR : RESP;
         end
         RMW_WR: begin
            wr_en   = 1'b1;
            state_d = RESP;
         end
         RESP: state_d = bus.rsp_ready ? IDLE : RESP;
         default: state_d = IDLE;
      endcase
   end
endmodule
